fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter for NREQ producers feeding one
// synchronous LUTRAM FIFO of DEPTH entries.
//
// Occupancy tracks accepted entries, including the one still in the write
// register, so the FIFO can never be overrun even though the write lags the
// accept by one cycle. A dequeue in the same cycle frees a slot immediately.
//
// Optional feature: define FIFO_ARB_STATS_EN to build the per-producer
// saturating grant counters; otherwise grant_cnt is tied to zero.

module fifo_wr_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned DEPTH  = 64
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [NREQ-1:0]                req_valid,
   input  logic [NREQ-1:0][DWIDTH-1:0]    req_data,
   output logic [NREQ-1:0]                req_ready,
   output logic [DWIDTH-1:0]              fifo_din,
   output logic                           fifo_we,
   input  logic                           fifo_re,
   input  logic                           fifo_full,
   output logic [$clog2(DEPTH):0]         occupancy,
   output logic [$clog2(NREQ)-1:0]        grant_id,
   output logic [NREQ-1:0][15:0]          grant_cnt
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned OCW = $clog2(DEPTH) + 1;
   localparam logic [OCW-1:0] DEPTH_V = OCW'(DEPTH);
   localparam logic [IDW:0]   NREQ_V  = (IDW + 1)'(NREQ);
   localparam logic [IDW-1:0] LAST_V  = IDW'(NREQ - 1);

   // Elaboration-time parameter sanity checks.
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("fifo_wr_arbiter: NREQ must be in 2..8");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_wr_arbiter: DEPTH must be a power of two");
   end

   // State
   logic [IDW-1:0]    rr_q, rr_d;
   logic [OCW-1:0]    occ_q, occ_d;
   logic [DWIDTH-1:0] din_q, din_d;
   logic              we_q, we_d;
   logic [IDW-1:0]    grant_q, grant_d;

   // Arbitration signals
   logic              re_ok;
   logic [OCW-1:0]    occ_eff;
   logic              space;
   logic              found;
   logic [IDW-1:0]    win;
   logic [IDW:0]      scan_sum;
   logic              accept;

   // A dequeue only counts when something is actually held; this keeps the
   // counter from wrapping below zero even if the consumer misbehaves.
   assign re_ok   = fifo_re && (occ_q != '0);
   assign occ_eff = occ_q - OCW'(re_ok);
   assign space   = (occ_eff < DEPTH_V);

   // Round-robin search: first valid producer at or after rr, wrapping.
   always_comb begin
      found    = 1'b0;
      win      = rr_q;
      scan_sum = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         scan_sum = {1'b0, rr_q} + (IDW + 1)'(off);
         if (scan_sum >= NREQ_V) begin
            scan_sum = scan_sum - NREQ_V;
         end
         if (!found && req_valid[scan_sum[IDW-1:0]]) begin
            found = 1'b1;
            win   = scan_sum[IDW-1:0];
         end
      end
   end

   // Accept is masked by rstn so req_ready reads all-zero during reset.
   assign accept = found && space && rstn;

   // One-hot ready towards the winning producer.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[win] = 1'b1;
      end
   end

   // Next-state: pointer, grant id, write register and occupancy.
   always_comb begin
      rr_d    = rr_q;
      grant_d = grant_q;
      din_d   = din_q;
      we_d    = 1'b0;
      occ_d   = occ_q;

      if (accept) begin
         rr_d    = (win == LAST_V) ? '0 : win + IDW'(1);
         grant_d = win;
         din_d   = req_data[win];
         we_d    = 1'b1;
      end

      unique case ({accept, re_ok})
         2'b10: begin
            if (occ_q != DEPTH_V) begin
               occ_d = occ_q + OCW'(1);
            end
         end
         2'b01:   occ_d = occ_q - OCW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset also drops any accept in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_q    <= '0;
         grant_q <= '0;
         din_q   <= '0;
         we_q    <= 1'b0;
         occ_q   <= '0;
      end else begin
         rr_q    <= rr_d;
         grant_q <= grant_d;
         din_q   <= din_d;
         we_q    <= we_d;
         occ_q   <= occ_d;
      end
   end

   assign fifo_din  = din_q;
   assign fifo_we   = we_q;
   assign occupancy = occ_q;
   assign grant_id  = grant_q;

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_cnt
      // Saturating per-producer grant counter.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            cnt_q[i] <= '0;
         end else if (accept && (win == IDW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
      assign grant_cnt[i] = cnt_q[i];
   end
`else
   assign grant_cnt = '0;
`endif

   // Simulation checks on the consumer and FIFO handshake.
   a_no_write_when_full : assert property (
      @(posedge clk) disable iff (!rstn) !(fifo_we && fifo_full))
      else $error("fifo_wr_arbiter: fifo_we asserted while fifo_full is high");

   a_consumer_underflow : assert property (
      @(posedge clk) disable iff (!rstn) fifo_re |-> (occupancy != '0))
      else $error("fifo_wr_arbiter: consumer underflow, fifo_re with occupancy 0");

   a_ready_onehot : assert property (
      @(posedge clk) disable iff (!rstn) $onehot0(req_ready))
      else $error("fifo_wr_arbiter: req_ready not one-hot");

   a_occ_bound : assert property (
      @(posedge clk) disable iff (!rstn) occupancy <= DEPTH_V)
      else $error("fifo_wr_arbiter: occupancy above DEPTH");

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (default parameters).
// Build with +define+FIFO_ARB_STATS_EN to exercise the grant counters.

module tb_fifo_wr_arbiter;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned DWIDTH = 32;
   localparam int unsigned DEPTH  = 64;

   logic                        clk = 1'b0;
   logic                        rstn = 1'b0;
   logic [NREQ-1:0]             req_valid = '0;
   logic [NREQ-1:0][DWIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]             req_ready;
   logic [DWIDTH-1:0]           fifo_din;
   logic                        fifo_we;
   logic                        fifo_re = 1'b0;
   logic                        fifo_full;
   logic [6:0]                  occupancy;
   logic [1:0]                  grant_id;
   logic [NREQ-1:0][15:0]       grant_cnt;

   int vec  = 0;
   int errs = 0;
   int fifo_cnt;
   int full_viol = 0;

   fifo_wr_arbiter #(
      .NREQ   (NREQ),
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_din  (fifo_din),
      .fifo_we   (fifo_we),
      .fifo_re   (fifo_re),
      .fifo_full (fifo_full),
      .occupancy (occupancy),
      .grant_id  (grant_id),
      .grant_cnt (grant_cnt)
   );

   always #5 clk = ~clk;

   // Model of the downstream FIFO fill level, driving fifo_full.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) fifo_cnt <= 0;
      else       fifo_cnt <= fifo_cnt + (fifo_we ? 1 : 0) - (fifo_re ? 1 : 0);
   end
   assign fifo_full = (fifo_cnt >= int'(DEPTH));

   always @(negedge clk) begin
      if (fifo_we && fifo_full) full_viol++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      req_valid = '0;
      fifo_re   = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      req_valid = '1;
      #3;
      vec++; if (occupancy !== 7'd0) begin errs++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      vec++; if (fifo_we !== 1'b0) begin errs++; $display("FAIL reset_we got %b want 0", fifo_we); end
      vec++; if (fifo_din !== '0) begin errs++; $display("FAIL reset_din got %h want 0", fifo_din); end
      vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL reset_gid got %0d want 0", grant_id); end
      vec++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      vec++; if (grant_cnt !== '0) begin errs++; $display("FAIL reset_cnt got %h want 0", grant_cnt); end
      tick();
      vec++; if (fifo_we !== 1'b0) begin errs++; $display("FAIL reset_we_edge got %b want 0", fifo_we); end
      rstn = 1'b1;
   endtask

   // All four valid, no dequeue: 0,1,2,3,... until 64 accepts.
   task automatic test_fill();
      logic [NREQ-1:0] exp_rdy;
      req_valid = '1;
      fifo_re   = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) req_data[i] = 32'hD0D0_0000 + i;
      for (int n = 0; n < 70; n++) begin
         #1;
         exp_rdy = (n < 64) ? (4'b0001 << (n % 4)) : 4'b0000;
         vec++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL fill_ready[%0d] got %b want %b", n, req_ready, exp_rdy); end
         tick();
         if (n < 64) begin
            vec++; if (fifo_we !== 1'b1) begin errs++; $display("FAIL fill_we[%0d] got %b want 1", n, fifo_we); end
            vec++; if (fifo_din !== 32'hD0D0_0000 + n % 4) begin errs++; $display("FAIL fill_din[%0d] got %h want %h", n, fifo_din, 32'hD0D0_0000 + n % 4); end
            vec++; if (grant_id !== 2'(n % 4)) begin errs++; $display("FAIL fill_gid[%0d] got %0d want %0d", n, grant_id, n % 4); end
            vec++; if (occupancy !== 7'(n + 1)) begin errs++; $display("FAIL fill_occ[%0d] got %0d want %0d", n, occupancy, n + 1); end
         end else begin
            vec++; if (fifo_we !== 1'b0) begin errs++; $display("FAIL fill_stop_we[%0d] got %b want 0", n, fifo_we); end
         end
      end
      vec++; if (occupancy !== 7'd64) begin errs++; $display("FAIL fill_final_occ got %0d want 64", occupancy); end
      vec++; if (full_viol !== 0) begin errs++; $display("FAIL fill_we_when_full got %0d want 0", full_viol); end
`ifndef FIFO_ARB_STATS_EN
      vec++; if (grant_cnt !== '0) begin errs++; $display("FAIL fill_cnt_tied got %h want 0", grant_cnt); end
`endif
   endtask

   // Full FIFO with a dequeue: producer 2 still gets in.
   task automatic test_boundary();
      req_valid = 4'b0100;
      req_data[2] = 32'hB0B0_0002;
      fifo_re = 1'b1;
      #1;
      vec++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL bound_ready got %b want 0100", req_ready); end
      tick();
      fifo_re = 1'b0;
      req_valid = '0;
      vec++; if (fifo_we !== 1'b1) begin errs++; $display("FAIL bound_we got %b want 1", fifo_we); end
      vec++; if (fifo_din !== 32'hB0B0_0002) begin errs++; $display("FAIL bound_din got %h want b0b00002", fifo_din); end
      vec++; if (occupancy !== 7'd64) begin errs++; $display("FAIL bound_occ got %0d want 64", occupancy); end
      vec++; if (grant_id !== 2'd2) begin errs++; $display("FAIL bound_gid got %0d want 2", grant_id); end
   endtask

   // Drain to 5, then accept and dequeue together.
   task automatic test_same_cycle();
      req_valid = '0;
      fifo_re   = 1'b1;
      repeat (59) tick();
      fifo_re = 1'b0;
      vec++; if (occupancy !== 7'd5) begin errs++; $display("FAIL drain_occ got %0d want 5", occupancy); end
      // rr is 3 after producer 2; only producer 0 valid -> wraps to 0.
      req_valid = 4'b0001;
      req_data[0] = 32'h5A5A_0000;
      fifo_re = 1'b1;
      #1;
      vec++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL same_ready got %b want 0001", req_ready); end
      tick();
      fifo_re = 1'b0;
      req_valid = '0;
      vec++; if (occupancy !== 7'd5) begin errs++; $display("FAIL same_occ got %0d want 5", occupancy); end
      vec++; if (fifo_we !== 1'b1) begin errs++; $display("FAIL same_we got %b want 1", fifo_we); end
      vec++; if (fifo_din !== 32'h5A5A_0000) begin errs++; $display("FAIL same_din got %h want 5a5a0000", fifo_din); end
   endtask

   // Producers 1 and 3 only, from rr=0: 1,3,1,3,...
   task automatic test_alternate();
      logic [NREQ-1:0] exp_rdy;
      logic [DWIDTH-1:0] exp_din;
      do_reset();
      req_valid = 4'b1010;
      for (int n = 0; n < 6; n++) begin
         req_data[1] = 32'h1111_0000 + n;
         req_data[3] = 32'h3333_0000 + n;
         exp_rdy = (n % 2 == 0) ? 4'b0010 : 4'b1000;
         exp_din = (n % 2 == 0) ? 32'h1111_0000 + n : 32'h3333_0000 + n;
         #1;
         vec++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL alt_ready[%0d] got %b want %b", n, req_ready, exp_rdy); end
         tick();
         vec++; if (grant_id !== ((n % 2 == 0) ? 2'd1 : 2'd3)) begin errs++; $display("FAIL alt_gid[%0d] got %0d want %0d", n, grant_id, (n % 2 == 0) ? 1 : 3); end
         vec++; if (fifo_din !== exp_din) begin errs++; $display("FAIL alt_din[%0d] got %h want %h", n, fifo_din, exp_din); end
         vec++; if (fifo_we !== 1'b1) begin errs++; $display("FAIL alt_we[%0d] got %b want 1", n, fifo_we); end
      end
      vec++; if (occupancy !== 7'd6) begin errs++; $display("FAIL alt_occ got %0d want 6", occupancy); end
   endtask

   // Reset mid-stream with occupancy 20 and an accept pending.
   task automatic test_reset_midstream();
      do_reset();
      req_valid = '1;
      for (int i = 0; i < int'(NREQ); i++) req_data[i] = 32'hC0C0_0000 + i;
      repeat (20) tick();
      vec++; if (occupancy !== 7'd20) begin errs++; $display("FAIL mid_occ_pre got %0d want 20", occupancy); end
      #1;
      vec++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_pending got %b want 0001", req_ready); end
      rstn = 1'b0;
      #1;
      vec++; if (occupancy !== 7'd0) begin errs++; $display("FAIL mid_occ got %0d want 0", occupancy); end
      vec++; if (fifo_we !== 1'b0) begin errs++; $display("FAIL mid_we got %b want 0", fifo_we); end
      vec++; if (fifo_din !== '0) begin errs++; $display("FAIL mid_din got %h want 0", fifo_din); end
      vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL mid_gid got %0d want 0", grant_id); end
      vec++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL mid_ready got %b want 0000", req_ready); end
      tick();
      vec++; if (fifo_we !== 1'b0) begin errs++; $display("FAIL mid_we_edge got %b want 0", fifo_we); end
      rstn = 1'b1;
      req_valid = 4'b0110;
      #1;
      vec++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL mid_first_ready got %b want 0010", req_ready); end
      tick();
      req_valid = '0;
      vec++; if (fifo_we !== 1'b1) begin errs++; $display("FAIL mid_first_we got %b want 1", fifo_we); end
      vec++; if (fifo_din !== 32'hC0C0_0001) begin errs++; $display("FAIL mid_first_din got %h want c0c00001", fifo_din); end
      vec++; if (grant_id !== 2'd1) begin errs++; $display("FAIL mid_first_gid got %0d want 1", grant_id); end
      vec++; if (occupancy !== 7'd1) begin errs++; $display("FAIL mid_first_occ got %0d want 1", occupancy); end
      tick();
      vec++; if (fifo_we !== 1'b0) begin errs++; $display("FAIL mid_idle_we got %b want 0", fifo_we); end
      vec++; if (fifo_din !== 32'hC0C0_0001) begin errs++; $display("FAIL mid_hold_din got %h want c0c00001", fifo_din); end
   endtask

   // 70000 grants to producer 0 with a steady dequeue.
   task automatic test_stats();
      do_reset();
      req_valid = 4'b0001;
      req_data[0] = 32'h0000_0F0F;
      tick();
      fifo_re = 1'b1;
      repeat (69999) tick();
      req_valid = '0;
      vec++; if (occupancy !== 7'd1) begin errs++; $display("FAIL stats_occ got %0d want 1", occupancy); end
`ifdef FIFO_ARB_STATS_EN
      vec++; if (grant_cnt[0] !== 16'hFFFF) begin errs++; $display("FAIL stats_cnt0 got %h want ffff", grant_cnt[0]); end
      for (int i = 1; i < int'(NREQ); i++) begin
         vec++; if (grant_cnt[i] !== 16'h0000) begin errs++; $display("FAIL stats_cnt%0d got %h want 0", i, grant_cnt[i]); end
      end
`else
      vec++; if (grant_cnt !== '0) begin errs++; $display("FAIL stats_cnt_tied got %h want 0", grant_cnt); end
`endif
      tick();
      fifo_re = 1'b0;
      vec++; if (occupancy !== 7'd0) begin errs++; $display("FAIL stats_drain got %0d want 0", occupancy); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_boundary();
      test_same_cycle();
      test_alternate();
      test_reset_midstream();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
